pc_unit: RTL
============

Name: pc_unit

Overview:
Parametrised successor to the fixed 16-bit program counter. Holds the fetch address and selects the next PC internally: sequential increment, absolute jump, PC-relative branch, call and return. Call/return use an internal return-address stack (RAS). Sits at the front of the fetch stage, drives the instruction-memory address, and takes control inputs from decode/execute.

Parameters:
ADDR_WIDTH, 16, width of the PC and of all addresses.
OFFSET_WIDTH, 8, width of the signed branch offset.
INC, 1, sequential increment added per advancing cycle.
RESET_VECTOR, 16'h0000, PC value after reset (ADDR_WIDTH bits).
RAS_DEPTH, 4, return-stack entries; power of two, ≥2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
stall  input  1  hold all state this cycle.
jump  input  1  absolute jump request.
jump_target  input  ADDR_WIDTH  jump/call destination.
branch_taken  input  1  relative branch request.
branch_offset  input  OFFSET_WIDTH  signed offset, two's complement.
call  input  1  push return address, go to jump_target.
ret  input  1  pop return address, go to it.
pc  output  ADDR_WIDTH  current fetch address (registered).
ras_count  output  $clog2(RAS_DEPTH)+1  valid stack entries.
ras_empty  output  1  ras_count == 0.
ras_full  output  1  ras_count == RAS_DEPTH.
ras_overflow  output  1  sticky: call issued while full.
ras_underflow  output  1  sticky: ret issued while empty.

Behaviour:
- Reset (reset = 0, asynchronous): pc = RESET_VECTOR; ras_count = 0; both sticky flags = 0; stack contents don't-care. Release is synchronised externally. The first update occurs on the first rising edge with reset = 1.
- All state updates occur on the rising clk edge. pc changes exactly one cycle after the request is sampled. No combinational path from inputs to pc.
- Priority, highest first: stall > ret > call > jump > branch_taken > increment. Lower-priority requests in the same cycle are ignored.
- stall = 1: pc, stack, count and flags all hold.
- ret, count > 0: pc <= top entry; count decrements.
- ret, count = 0: pc <= pc + INC; ras_underflow <= 1; count stays 0.
- call, count < RAS_DEPTH: push pc + INC; pc <= jump_target; count increments.
- call, count = RAS_DEPTH: the stack is circular. Overwrite the oldest entry with pc + INC, which becomes the new top. pc <= jump_target; count stays RAS_DEPTH; ras_overflow <= 1.
- jump: pc <= jump_target.
- branch_taken: pc <= pc + sign_extend(branch_offset). The offset is relative to the current pc, not pc + INC.
- Otherwise: pc <= pc + INC.
- All address arithmetic is modulo 2^ADDR_WIDTH. Wrap-around is silent and sets no flag.
- Sticky flags clear only on reset.
- ras_empty and ras_full are combinational decodes of ras_count.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_WIDTH default constant.
  - RESET_VECTOR constant.
  - pc_sel enum {PC_HOLD, PC_RET, PC_CALL, PC_JUMP, PC_BRANCH, PC_INC} for the priority mux.
- One natural sub-module: return_stack. It is a circular LIFO with push, pop, top, count and sticky over/underflow flags, parametrised by RAS_DEPTH and ADDR_WIDTH. pc_unit keeps the priority mux and the PC register.

Test Plan:
(All scenarios use ADDR_WIDTH=16, INC=1, RESET_VECTOR=0, RAS_DEPTH=4.)
1. Reset/increment: hold reset = 0 for 2 edges, then release, no requests for 3 edges -> pc = 0x0000 during reset, then 0x0001, 0x0002, 0x0003. Assert reset = 0 mid-cycle -> pc = 0x0000 immediately, without waiting for an edge.
2. Jump/branch/wrap:
   - jump to 0x1111 -> pc = 0x1111.
   - branch_offset = 8'hF0 (−16) -> pc = 0x1101.
   - jump to 0xFFFF, then idle -> pc = 0x0000.
   - branch +2 from 0xFFFF -> pc = 0x0001.
3. Call/return nesting:
   - At pc = 0x0010, call 0x2000 -> pc = 0x2000, count = 1.
   - At 0x2000, call 0x3000 -> count = 2.
   - ret -> pc = 0x2001.
   - ret -> pc = 0x0011, count = 0, ras_empty = 1.
4. Overflow/underflow:
   - 5 consecutive calls from pc values A..E -> ras_full = 1, ras_overflow = 1.
   - 4 rets return E+1, D+1, C+1, B+1 in that order (A's entry was lost).
   - 5th ret -> pc = pc + 1, ras_underflow = 1. Both flags stay set until reset.
5. Priority/stall:
   - ret + call + jump + branch in one cycle with count = 1 -> ret wins; stack not pushed.
   - stall = 1 together with jump for 3 edges -> pc and count unchanged.
   - Drop stall while jump is still held -> jump takes effect on the next edge.
6. Parametrisation: ADDR_WIDTH = 8, INC = 2, RESET_VECTOR = 8'hFE -> pc = 0xFE, then 0x00, then 0x02.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default address geometry and the
// next-PC source selector used by the program-counter priority mux.
package cpu_pkg;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
   localparam logic [DEFAULT_ADDR_WIDTH-1:0] DEFAULT_RESET_VECTOR = 16'h0000;

   // Next-PC source, listed from highest to lowest priority.
   typedef enum logic [2:0] {
      PC_HOLD,
      PC_RET,
      PC_CALL,
      PC_JUMP,
      PC_BRANCH,
      PC_INC
   } pc_sel_e;

endpackage

// File: rtl/pc_unit_return_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry; a pop while empty only raises the sticky underflow flag.
module return_stack
   import cpu_pkg::*;
#(
   parameter int unsigned RAS_DEPTH  = 4,
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   localparam int unsigned CW = $clog2(RAS_DEPTH) + 1,
   localparam int unsigned PW = $clog2(RAS_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [ADDR_WIDTH-1:0] push_data_i,
   output logic [ADDR_WIDTH-1:0] top_o,
   output logic [CW-1:0]         count_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [PW-1:0]         tos_q, tos_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  full, empty;

   assign full  = (count_q == CW'(RAS_DEPTH));
   assign empty = (count_q == '0);

   // Pointer/count/flag next state; the pointer wraps naturally because the
   // depth is a power of two, which makes the full-stack push circular.
   always_comb begin
      tos_d   = tos_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (push_i) begin
         tos_d = tos_q + 1'b1;
         if (full) ovf_d = 1'b1;
         else      count_d = count_q + 1'b1;
      end else if (pop_i) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            tos_d   = tos_q - 1'b1;
            count_d = count_q - 1'b1;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tos_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         tos_q   <= tos_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Entry storage; contents are irrelevant after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[tos_d] <= push_data_i;
   end

   assign top_o       = mem_q[tos_q];
   assign count_o     = count_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter for the fetch stage: registered PC with a fixed-priority
// next-PC mux (stall > ret > call > jump > branch > increment) and an
// internal return-address stack for call/return.
module pc_unit
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int unsigned OFFSET_WIDTH = 8,
   parameter int unsigned INC          = 1,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
   parameter int unsigned RAS_DEPTH    = 4,
   localparam int unsigned CW = $clog2(RAS_DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    jump,
   input  logic [ADDR_WIDTH-1:0]   jump_target,
   input  logic                    branch_taken,
   input  logic [OFFSET_WIDTH-1:0] branch_offset,
   input  logic                    call,
   input  logic                    ret,
   output logic [ADDR_WIDTH-1:0]   pc,
   output logic [CW-1:0]           ras_count,
   output logic                    ras_empty,
   output logic                    ras_full,
   output logic                    ras_overflow,
   output logic                    ras_underflow
);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] pc_branch;
   logic [ADDR_WIDTH-1:0] ras_top;
   pc_sel_e               sel;

   assign pc_inc    = pc_q + ADDR_WIDTH'(INC);
   // Size cast of a signed operand sign-extends the offset to address width.
   assign pc_branch = pc_q + ADDR_WIDTH'($signed(branch_offset));

   // Resolve the winning request; lower-priority requests are ignored.
   always_comb begin
      sel = PC_INC;
      if      (stall)        sel = PC_HOLD;
      else if (ret)          sel = PC_RET;
      else if (call)         sel = PC_CALL;
      else if (jump)         sel = PC_JUMP;
      else if (branch_taken) sel = PC_BRANCH;
   end

   // Next-PC selection; a return on an empty stack falls through to increment.
   always_comb begin
      pc_d = pc_inc;
      case (sel)
         PC_HOLD:   pc_d = pc_q;
         PC_RET:    pc_d = ras_empty ? pc_inc : ras_top;
         PC_CALL:   pc_d = jump_target;
         PC_JUMP:   pc_d = jump_target;
         PC_BRANCH: pc_d = pc_branch;
         default:   pc_d = pc_inc;
      endcase
   end

   // PC register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc_q <= RESET_VECTOR;
      else        pc_q <= pc_d;
   end

   return_stack #(
      .RAS_DEPTH  (RAS_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ras (
      .clk         (clk),
      .rst_n       (reset),
      .push_i      (sel == PC_CALL),
      .pop_i       (sel == PC_RET),
      .push_data_i (pc_inc),
      .top_o       (ras_top),
      .count_o     (ras_count),
      .overflow_o  (ras_overflow),
      .underflow_o (ras_underflow)
   );

   assign pc        = pc_q;
   assign ras_empty = (ras_count == '0);
   assign ras_full  = (ras_count == CW'(RAS_DEPTH));

endmodule
